// File: rtl/elbeth_pkg.sv
// Shared definitions for the ELBETH hazard/forwarding controller:
// operand-select encodings, the pipeline tracking-slot record and the
// "slot produces register" predicate used by every comparator.
package elbeth_pkg;

  localparam int REG_ADDR_W = 5;

  // EX-stage operand mux encodings
  localparam logic [1:0] FWD_RF  = 2'b00;  // register file value
  localparam logic [1:0] FWD_MEM = 2'b01;  // result held in the MEM stage
  localparam logic [1:0] FWD_WB  = 2'b10;  // result held in the WB stage

  // What the controller remembers about the instruction in one stage
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
  } slot_t;

  // x0 is hard-wired to zero, so it is never considered "produced".
  function automatic logic slot_produces(input slot_t s, input logic [REG_ADDR_W-1:0] r);
    return s.valid && s.reg_write && (s.rd == r) && (r != '0);
  endfunction

endpackage

// File: rtl/elbeth_fwd_compare.sv
// Per-operand dependency check against the EX and MEM tracking slots.
// Build option: ELBETH_FWD_EN. When defined the comparator returns a
// forwarding select and flags only load producers in EX; when undefined
// the select is always register-file and any EX/MEM producer interlocks.
module elbeth_fwd_compare
  import elbeth_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic                  use_rs,
  input  slot_t                 ex_slot,
  input  slot_t                 mem_slot,
  output logic [1:0]            sel,
  output logic                  load_hit
);

  logic ex_hit;
  logic mem_hit;

  assign ex_hit  = use_rs && slot_produces(ex_slot, rs);
  assign mem_hit = use_rs && slot_produces(mem_slot, rs);

`ifdef ELBETH_FWD_EN
  // Youngest producer wins: EX result before MEM result
  always_comb begin
    sel = FWD_RF;
    if (ex_hit)
      sel = FWD_MEM;
    else if (mem_hit)
      sel = FWD_WB;
    load_hit = ex_hit && ex_slot.mem_read;
  end
`else
  // No bypass network: every in-flight producer forces an interlock
  always_comb begin
    sel      = FWD_RF;
    load_hit = ex_hit || mem_hit;
  end
`endif

endmodule

// File: rtl/elbeth_hazard_unit.sv
// Hazard and forwarding controller for the ELBETH 32-bit pipeline.
// Tracks EX/MEM/WB destination registers, produces registered operand
// selects for the EX muxes, and inserts a bubble on load-use hazards.
// Build option: ELBETH_FWD_EN (see elbeth_fwd_compare for its effect).
module elbeth_hazard_unit
  import elbeth_pkg::*;
#(
  parameter int REG_ADDR_W = elbeth_pkg::REG_ADDR_W,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  ex_flush,
  input  logic                  mem_stall,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  id_stall,
  output logic                  ex_bubble,
  output logic [CNT_W-1:0]      stall_cnt
);

  slot_t ex_slot;
  slot_t mem_slot;
  slot_t wb_slot;   // kept for completeness; write-first RF needs no WB bypass

  logic [REG_ADDR_W-1:0] src_idx [2];
  logic                  src_use [2];
  logic [1:0]            src_sel [2];
  logic                  src_hit [2];
  logic                  hz;

  assign src_idx[0] = id_rs1;
  assign src_idx[1] = id_rs2;
  assign src_use[0] = id_use_rs1;
  assign src_use[1] = id_use_rs2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_opnd
      elbeth_fwd_compare u_cmp (
        .rs       (src_idx[gi]),
        .use_rs   (src_use[gi]),
        .ex_slot  (ex_slot),
        .mem_slot (mem_slot),
        .sel      (src_sel[gi]),
        .load_hit (src_hit[gi])
      );
    end
  endgenerate

  // Hazard decision; flush overrides the stall but still forces a bubble
  always_comb begin
    hz        = id_valid && (src_hit[0] || src_hit[1]);
    id_stall  = hz && !ex_flush && !mem_stall;
    ex_bubble = (hz || ex_flush) && !mem_stall;
  end

  // Advance tracking slots and selects; mem_stall freezes everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_slot   <= '0;
      mem_slot  <= '0;
      wb_slot   <= '0;
      fwd_a_sel <= FWD_RF;
      fwd_b_sel <= FWD_RF;
    end else if (!mem_stall) begin
      wb_slot  <= mem_slot;
      mem_slot <= ex_slot;
      if (ex_bubble) begin
        ex_slot   <= '0;
        fwd_a_sel <= FWD_RF;
        fwd_b_sel <= FWD_RF;
      end else begin
        ex_slot.valid     <= id_valid;
        ex_slot.rd        <= id_rd;
        ex_slot.reg_write <= id_reg_write;
        ex_slot.mem_read  <= id_mem_read;
        fwd_a_sel         <= src_sel[0];
        fwd_b_sel         <= src_sel[1];
      end
    end
  end

  // Saturating count of interlock cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (id_stall && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_elbeth_hazard_unit.sv
// Self-checking bench for elbeth_hazard_unit. Expected values come from
// hand-derived vector tables (one per ELBETH_FWD_EN setting); registered
// results are queued when a row is driven and compared after the edge.
module tb_elbeth_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
  logic       ex_flush, mem_stall;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       id_stall, ex_bubble;
  logic [15:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  elbeth_hazard_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .ex_flush     (ex_flush),
    .mem_stall    (mem_stall),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel),
    .id_stall     (id_stall),
    .ex_bubble    (ex_bubble),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       rw, mr, fl, ms;
    logic       st, bb;      // expected combinational outputs this cycle
    logic [1:0] a, b;        // expected selects after the edge
    int         cnt;         // expected stall_cnt after the edge
  } vec_t;

  typedef struct {
    int         row;
    logic [1:0] a, b;
    int         cnt;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];

  function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic u1,
                              input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                              input logic rw, input logic mr, input logic fl, input logic ms,
                              input logic st, input logic bb, input logic [1:0] a,
                              input logic [1:0] b, input int cnt);
    vec_t r;
    r.v = v; r.rs1 = rs1; r.u1 = u1; r.rs2 = rs2; r.u2 = u2; r.rd = rd;
    r.rw = rw; r.mr = mr; r.fl = fl; r.ms = ms;
    r.st = st; r.bb = bb; r.a = a; r.b = b; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0d, expected %0d", name, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    id_valid     = t.v;
    id_rs1       = t.rs1;
    id_use_rs1   = t.u1;
    id_rs2       = t.rs2;
    id_use_rs2   = t.u2;
    id_rd        = t.rd;
    id_reg_write = t.rw;
    id_mem_read  = t.mr;
    ex_flush     = t.fl;
    mem_stall    = t.ms;
  endtask

  initial begin
    vec_t idle;
    vec_t cons;
    sb_t  e;

    idle = mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0);
`ifdef ELBETH_FWD_EN
    //                v rs1 u1 rs2 u2 rd rw mr fl ms  st bb a b cnt
    vecs.push_back(mk(1, 1,1, 2,1, 5,1,0,0,0, 0,0,0,0,0)); // add x5
    vecs.push_back(mk(1, 5,1, 6,1, 8,1,0,0,0, 0,0,1,0,0)); // sub uses x5 -> EX fwd
    vecs.push_back(mk(1, 0,1, 0,0, 7,1,0,0,0, 0,0,0,0,0)); // write x7
    vecs.push_back(mk(1, 3,1, 0,0, 7,1,0,0,0, 0,0,0,0,0)); // write x7 again
    vecs.push_back(mk(1, 8,1, 7,1,10,1,0,0,0, 0,0,0,1,0)); // EX and MEM both x7 -> 01
    vecs.push_back(mk(1,10,1, 7,1,11,1,0,0,0, 0,0,1,2,0)); // only MEM x7 -> 10
    vecs.push_back(mk(1, 2,1, 0,0, 9,1,1,0,0, 0,0,0,0,0)); // load x9
    vecs.push_back(mk(1, 9,1,11,1,12,1,0,0,0, 1,1,0,0,1)); // load-use stall
    vecs.push_back(mk(1, 9,1,11,1,12,1,0,0,0, 0,0,2,0,1)); // retry -> 10
    vecs.push_back(mk(1,12,1, 0,0,13,1,1,0,0, 0,0,1,0,1)); // load x13
    vecs.push_back(mk(1, 0,0,13,1,15,1,0,1,0, 0,1,0,0,1)); // load-use + flush
    vecs.push_back(mk(1,13,1, 0,0, 0,1,1,0,0, 0,0,2,0,1)); // load into x0
    vecs.push_back(mk(1, 0,1, 0,1, 3,1,0,0,0, 0,0,0,0,1)); // read x0
    vecs.push_back(mk(1, 3,1, 0,0, 4,1,1,0,0, 0,0,1,0,1)); // load x4
    vecs.push_back(mk(1, 3,1, 4,1,14,1,0,0,1, 0,0,1,0,1)); // mem_stall x3
    vecs.push_back(mk(1, 3,1, 4,1,14,1,0,0,1, 0,0,1,0,1));
    vecs.push_back(mk(1, 3,1, 4,1,14,1,0,0,1, 0,0,1,0,1));
    vecs.push_back(mk(1, 3,1, 4,1,14,1,0,0,0, 1,1,0,0,2)); // stall released
    vecs.push_back(mk(1, 3,1, 4,1,14,1,0,0,0, 0,0,0,2,2));
    vecs.push_back(mk(1,14,1, 0,0, 0,0,0,0,0, 0,0,1,0,2));
    vecs.push_back(mk(1,14,1, 0,0, 9,1,1,0,0, 0,0,2,0,2)); // load x9
`else
    //                v rs1 u1 rs2 u2 rd rw mr fl ms  st bb a b cnt
    vecs.push_back(mk(1, 1,1, 2,1, 5,1,0,0,0, 0,0,0,0,0)); // add x5
    vecs.push_back(mk(1, 5,1, 6,1, 8,1,0,0,0, 1,1,0,0,1)); // dependent sub: EX
    vecs.push_back(mk(1, 5,1, 6,1, 8,1,0,0,0, 1,1,0,0,2)); // still waiting: MEM
    vecs.push_back(mk(1, 5,1, 6,1, 8,1,0,0,0, 0,0,0,0,2)); // issues
    vecs.push_back(mk(1, 2,1, 0,0, 9,1,1,0,0, 0,0,0,0,2)); // load x9
    vecs.push_back(mk(1, 9,1, 8,1,12,1,0,0,0, 1,1,0,0,3));
    vecs.push_back(mk(1, 9,1, 8,1,12,1,0,0,0, 1,1,0,0,4));
    vecs.push_back(mk(1, 9,1, 8,1,12,1,0,0,0, 0,0,0,0,4));
    vecs.push_back(mk(1, 0,1, 0,0,13,1,1,0,0, 0,0,0,0,4)); // load x13
    vecs.push_back(mk(1, 0,0,13,1,15,1,0,1,0, 0,1,0,0,4)); // hazard + flush
    vecs.push_back(mk(1, 0,1, 0,1, 0,1,1,0,0, 0,0,0,0,4)); // load into x0
    vecs.push_back(mk(1, 0,1, 0,1, 3,1,0,0,0, 0,0,0,0,4)); // read x0
    vecs.push_back(mk(1, 3,1, 0,0,20,1,0,0,1, 0,0,0,0,4)); // mem_stall x3
    vecs.push_back(mk(1, 3,1, 0,0,20,1,0,0,1, 0,0,0,0,4));
    vecs.push_back(mk(1, 3,1, 0,0,20,1,0,0,1, 0,0,0,0,4));
    vecs.push_back(mk(1, 3,1, 0,0,20,1,0,0,0, 1,1,0,0,5));
    vecs.push_back(mk(1, 3,1, 0,0,20,1,0,0,0, 1,1,0,0,6));
    vecs.push_back(mk(1, 3,1, 0,0,20,1,0,0,0, 0,0,0,0,6));
    vecs.push_back(mk(1,14,1, 0,0, 9,1,1,0,0, 0,0,0,0,6)); // load x9
`endif

    // Reset state
    rst_n = 1'b0;
    drive(idle);
    #1;
    chk("reset_fwd_a", -1, 32'(fwd_a_sel), 0);
    chk("reset_fwd_b", -1, 32'(fwd_b_sel), 0);
    chk("reset_cnt",   -1, 32'(stall_cnt), 0);
    chk("reset_stall", -1, 32'(id_stall), 0);
    chk("reset_bubble",-1, 32'(ex_bubble), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven sequence
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk("id_stall",  i, 32'(id_stall),  32'(vecs[i].st));
      chk("ex_bubble", i, 32'(ex_bubble), 32'(vecs[i].bb));
      e.row = i; e.a = vecs[i].a; e.b = vecs[i].b; e.cnt = vecs[i].cnt;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("fwd_a_sel", e.row, 32'(fwd_a_sel), 32'(e.a));
      chk("fwd_b_sel", e.row, 32'(fwd_b_sel), 32'(e.b));
      chk("stall_cnt", e.row, 32'(stall_cnt), 32'(e.cnt));
      $display("row %0d: stall=%0b bubble=%0b a=%0d b=%0d cnt=%0d",
               i, vecs[i].st, vecs[i].bb, fwd_a_sel, fwd_b_sel, stall_cnt);
    end

    // Asynchronous reset during a load-use stall
    cons = mk(1, 9,1, 0,0,12,1,0,0,0, 0,0,0,0,0);
    @(negedge clk);
    drive(cons);
    #1;
    chk("pre_rst_stall", -1, 32'(id_stall), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_stall",  -1, 32'(id_stall), 0);
    chk("async_rst_bubble", -1, 32'(ex_bubble), 0);
    chk("async_rst_fwd_a",  -1, 32'(fwd_a_sel), 0);
    chk("async_rst_fwd_b",  -1, 32'(fwd_b_sel), 0);
    chk("async_rst_cnt",    -1, 32'(stall_cnt), 0);
    $display("async reset: stall=%0b a=%0d cnt=%0d", id_stall, fwd_a_sel, stall_cnt);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(cons);
    #1;
    chk("post_rst_stall",  -1, 32'(id_stall), 0);
    chk("post_rst_bubble", -1, 32'(ex_bubble), 0);
    @(posedge clk);
    #1;
    chk("post_rst_fwd_a", -1, 32'(fwd_a_sel), 0);
    chk("post_rst_cnt",   -1, 32'(stall_cnt), 0);
    $display("post reset consumer: a=%0d cnt=%0d", fwd_a_sel, stall_cnt);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/elbeth_hazard_unit.md
# elbeth_hazard_unit

Hazard and forwarding controller for the ELBETH 32-bit pipeline. Tracks destination registers of instructions in EX, MEM and WB, and produces registered 2-bit operand-select codes for the EX-stage 3-to-1 operand muxes (00 = register file, 01 = MEM-stage result, 10 = WB-stage result). Detects load-use hazards and inserts exactly one bubble. Honours branch flush and memory stall.

## Interface
- REG_ADDR_W, 5, register index width
- CNT_W, 16, width of the stall-cycle performance counter
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  REG_ADDR_W  source register indices in ID
- id_use_rs1, id_use_rs2  in  1  the source is actually read
- id_rd  in  REG_ADDR_W  destination index in ID
- id_reg_write  in  1  ID instruction writes rd
- id_mem_read  in  1  ID instruction is a load
- ex_flush  in  1  taken branch/jump resolved in EX; kill ID
- mem_stall  in  1  data memory busy; freeze whole pipeline
- fwd_a_sel, fwd_b_sel  out  2  registered operand-select codes for the instruction now in EX
- id_stall  out  1  combinational; hold PC and IF/ID register
- ex_bubble  out  1  combinational; ID/EX register loads a NOP
- stall_cnt  out  CNT_W  saturating count of load-use stall cycles

## Operation
- Internal tracking slots EX, MEM, WB each hold {valid, rd, reg_write, mem_read}. A slot "produces r" iff valid && reg_write && rd == r && r != 0.
- Load-use: hz = id_valid && EX.mem_read && EX produces (id_rs1 with id_use_rs1, or id_rs2 with id_use_rs2).
- id_stall = hz && !ex_flush && !mem_stall. ex_bubble = (hz || ex_flush) && !mem_stall.
- Select per operand, computed from ID operands against current slots: EX produces rs -> 01; else MEM produces rs -> 10; else 00. EX takes priority over MEM (youngest producer wins). Unused operand -> 00.
- Clock edge, mem_stall = 0: WB <= MEM; MEM <= EX; EX <= ex_bubble ? invalid : {id_valid, id_rd, id_reg_write, id_mem_read}; fwd_*_sel <= ex_bubble ? 00 : computed selects.
- Clock edge, mem_stall = 1: all slots, selects and stall_cnt hold.
- Flush beats load-use: with ex_flush && hz, no stall, a bubble is inserted, and stall_cnt is not incremented.
- stall_cnt increments on each edge where id_stall = 1. It saturates at all-ones.
- The register file is write-first, so a WB-slot producer needs no forwarding.

## Timing
- Reset, asynchronous assert: all slots invalid, fwd_a_sel = fwd_b_sel = 00, stall_cnt = 0. id_stall = ex_bubble = 0, because the slots are invalid.
- Reset deassertion mid-operation discards all tracked state. There is no recovery of in-flight instructions.
- Selects have 1-cycle latency from ID and are valid for the whole cycle the instruction occupies EX.
- A load-use stall lasts exactly one cycle. On the next cycle the load is in MEM, the consumer recomputes, and it gets select 10.
- id_stall and ex_bubble have zero latency, combinational from inputs and slot state. They have no path from fwd_*_sel.

## Configuration
- ELBETH_FWD_EN defined: forwarding as above.
- ELBETH_FWD_EN undefined: selects are constant 00. hz is extended to "EX or MEM produces a used source", for any instruction type. Dependent instructions interlock for up to 2 cycles, and stall_cnt counts these cycles as well.

## Structure
- elbeth_pkg holds:
  - FWD_RF = 2'b00, FWD_MEM = 2'b01, FWD_WB = 2'b10
  - the tracking-slot struct typedef
  - REG_ADDR_W default
- One sub-module, elbeth_fwd_compare: given one source index, its use flag and the EX/MEM slots, it returns a 2-bit select and a load-hit flag. It is instantiated once per operand.

## Test plan
- Back-to-back dependency: add x5 then sub using rs1 = x5 -> sub in EX has fwd_a_sel = 01, id_stall never asserted.
- Distance-2 dependency, with both EX and MEM writing x7 and rs2 = x7 -> fwd_b_sel = 01 (EX wins). With only MEM writing x7 -> 10.
- Load x9 followed by a consumer of x9 -> id_stall = 1 for exactly one cycle, one bubble, consumer select = 10, stall_cnt 0 -> 1.
- Load-use with ex_flush = 1 in the same cycle -> id_stall = 0, ex_bubble = 1, stall_cnt unchanged.
- Writes to x0 followed by a read of x0 -> selects 00, no stall. Holding mem_stall for 3 cycles -> all outputs and stall_cnt frozen.
- Assert rst_n low during a stall -> selects 00, stall_cnt 0, id_stall 0 immediately (asynchronously). With ELBETH_FWD_EN undefined, add-then-dependent-sub -> 2 stall cycles, selects 00.
